// File: rtl/pw_ctrl_pkg.sv
// Shared types and sizing helpers for the password lockout controller.
package pw_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  localparam int DEFAULT_PRESC_BITS    = 4;
  localparam int DEFAULT_MAX_FAILS     = 3;
  localparam int DEFAULT_LOCK_TICKS    = 8;
  localparam int DEFAULT_SESSION_TICKS = 16;

  // Bits needed to hold a failure count from 0 up to and including max_fails.
  function automatic int fail_cnt_width(input int max_fails);
    int w;
    w = (max_fails < 1) ? 1 : $clog2(max_fails + 1);
    return w;
  endfunction

  // Bits needed for a tick counter that runs 0 .. (longest window - 1).
  function automatic int tick_cnt_width(input int lock_ticks, input int session_ticks);
    int longest;
    int w;
    longest = (lock_ticks > session_ticks) ? lock_ticks : session_ticks;
    w = (longest <= 2) ? 1 : $clog2(longest);
    return w;
  endfunction

endpackage

// File: rtl/pw_prescaler.sv
// Free-running prescaler: emits a one-cycle tick every 2**PRESC_BITS clocks.
// A synchronous clear restarts the count so a new timing window starts aligned.
module pw_prescaler #(
  parameter int PRESC_BITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  logic [PRESC_BITS-1:0] cnt_q;
  logic [PRESC_BITS-1:0] cnt_d;

  // Next count: restart on clear, otherwise count up and wrap naturally.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear) begin
      cnt_d = '0;
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == {PRESC_BITS{1'b1}});

endmodule

// File: rtl/pw_lockout_ctrl.sv
// Password lockout controller: counts failed attempts, locks out for a fixed
// time after too many failures, and grants a session window that is renewed
// by activity and closed by logout or inactivity timeout.
module pw_lockout_ctrl
  import pw_ctrl_pkg::*;
#(
  parameter int PRESC_BITS    = DEFAULT_PRESC_BITS,
  parameter int MAX_FAILS     = DEFAULT_MAX_FAILS,
  parameter int LOCK_TICKS    = DEFAULT_LOCK_TICKS,
  parameter int SESSION_TICKS = DEFAULT_SESSION_TICKS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           attempt_valid,
  input  logic                           attempt_ok,
  input  logic                           logout,
  input  logic                           activity,
  output logic                           attempt_ready,
  output logic                           access_en,
  output logic                           locked,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt,
  output logic                           expired
);

  localparam int FAIL_W = fail_cnt_width(MAX_FAILS);
  localparam int TICK_W = tick_cnt_width(LOCK_TICKS, SESSION_TICKS);

  localparam logic [FAIL_W-1:0] FAIL_MAX     = FAIL_W'(MAX_FAILS);
  localparam logic [FAIL_W-1:0] FAIL_LAST    = FAIL_W'(MAX_FAILS - 1);
  localparam logic [TICK_W-1:0] LOCK_LAST    = TICK_W'(LOCK_TICKS - 1);
  localparam logic [TICK_W-1:0] SESSION_LAST = TICK_W'(SESSION_TICKS - 1);

  state_e              state_q, state_d;
  logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic                expired_q, expired_d;
  logic                presc_clr;
  logic                tick;

  pw_prescaler #(
    .PRESC_BITS(PRESC_BITS)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clear(presc_clr),
    .tick (tick)
  );

  // Next-state logic: attempt handling in IDLE, timed exits from LOCKED and
  // UNLOCKED, with logout beating activity and activity beating timeout.
  always_comb begin
    state_d    = state_q;
    fail_cnt_d = fail_cnt_q;
    tick_cnt_d = tick_cnt_q;
    expired_d  = 1'b0;
    presc_clr  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (attempt_valid) begin
          if (attempt_ok) begin
            state_d    = ST_UNLOCKED;
            fail_cnt_d = '0;
            tick_cnt_d = '0;
            presc_clr  = 1'b1;
          end else if (fail_cnt_q == FAIL_LAST) begin
            state_d    = ST_LOCKED;
            fail_cnt_d = FAIL_MAX;
            tick_cnt_d = '0;
            presc_clr  = 1'b1;
          end else begin
            fail_cnt_d = fail_cnt_q + 1'b1;
          end
        end
      end

      ST_LOCKED: begin
        if (tick) begin
          if (tick_cnt_q == LOCK_LAST) begin
            state_d    = ST_IDLE;
            fail_cnt_d = '0;
            tick_cnt_d = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      ST_UNLOCKED: begin
        if (logout) begin
          state_d    = ST_IDLE;
          tick_cnt_d = '0;
        end else if (activity) begin
          tick_cnt_d = '0;
          presc_clr  = 1'b1;
        end else if (tick) begin
          if (tick_cnt_q == SESSION_LAST) begin
            state_d    = ST_IDLE;
            tick_cnt_d = '0;
            expired_d  = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d    = ST_IDLE;
        fail_cnt_d = '0;
        tick_cnt_d = '0;
      end
    endcase
  end

  // State, counters and the expiry pulse, all cleared by asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fail_cnt_q <= '0;
      tick_cnt_q <= '0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fail_cnt_q <= fail_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      expired_q  <= expired_d;
    end
  end

  assign attempt_ready = (state_q == ST_IDLE);
  assign access_en     = (state_q == ST_UNLOCKED);
  assign locked        = (state_q == ST_LOCKED);
  assign fail_cnt      = fail_cnt_q;
  assign expired       = expired_q;

endmodule

// File: tb/tb_pw_lockout_ctrl.sv
// Self-checking bench for pw_lockout_ctrl: a vector table, hand-written
// multi-cycle sequences and a randomized run against a cycle-count model.
module tb_pw_lockout_ctrl;

  localparam int PRESC_BITS     = 4;
  localparam int MAX_FAILS      = 3;
  localparam int LOCK_TICKS     = 8;
  localparam int SESSION_TICKS  = 16;
  localparam int TICK_CYCLES    = 1 << PRESC_BITS;
  localparam int LOCK_CYCLES    = LOCK_TICKS * TICK_CYCLES;
  localparam int SESSION_CYCLES = SESSION_TICKS * TICK_CYCLES;

  localparam int MODE_IDLE    = 0;
  localparam int MODE_SESSION = 1;
  localparam int MODE_LOCKOUT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       attempt_valid = 1'b0;
  logic       attempt_ok = 1'b0;
  logic       logout = 1'b0;
  logic       activity = 1'b0;
  logic       attempt_ready;
  logic       access_en;
  logic       locked;
  logic [1:0] fail_cnt;
  logic       expired;

  int tests = 0;
  int failures = 0;

  int m_mode;
  int m_fails;
  int m_elapsed;
  int m_expired;

  typedef struct {
    logic v;
    logic ok;
    logic lo;
    logic act;
    logic rdy;
    logic acc;
    logic lck;
    int   fc;
    logic ex;
  } vec_t;

  vec_t vecs[12];

  pw_lockout_ctrl #(
    .PRESC_BITS   (PRESC_BITS),
    .MAX_FAILS    (MAX_FAILS),
    .LOCK_TICKS   (LOCK_TICKS),
    .SESSION_TICKS(SESSION_TICKS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .attempt_valid(attempt_valid),
    .attempt_ok   (attempt_ok),
    .logout       (logout),
    .activity     (activity),
    .attempt_ready(attempt_ready),
    .access_en    (access_en),
    .locked       (locked),
    .fail_cnt     (fail_cnt),
    .expired      (expired)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Watchdog so a stuck run still ends with a visible failure.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model in terms of elapsed cycles within the current window.
  task automatic modelReset();
    m_mode = MODE_IDLE;
    m_fails = 0;
    m_elapsed = 0;
    m_expired = 0;
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic modelStep(input logic v, input logic ok, input logic lo, input logic act);
    m_expired = 0;
    case (m_mode)
      MODE_IDLE: begin
        if (v) begin
          if (ok) begin
            m_mode = MODE_SESSION;
            m_elapsed = 0;
            m_fails = 0;
          end else begin
            m_fails = m_fails + 1;
            if (m_fails == MAX_FAILS) begin
              m_mode = MODE_LOCKOUT;
              m_elapsed = 0;
            end
          end
        end
      end
      MODE_LOCKOUT: begin
        m_elapsed = m_elapsed + 1;
        if (m_elapsed == LOCK_CYCLES) begin
          m_mode = MODE_IDLE;
          m_fails = 0;
        end
      end
      default: begin
        if (lo) begin
          m_mode = MODE_IDLE;
        end else if (act) begin
          m_elapsed = 0;
        end else begin
          m_elapsed = m_elapsed + 1;
          if (m_elapsed == SESSION_CYCLES) begin
            m_mode = MODE_IDLE;
            m_expired = 1;
          end
        end
      end
    endcase
  endtask

  // One comparison of an observed value against a required value.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Compare every DUT output against the reference model.
  task automatic checkModel(input string tag);
    checkOutput({tag, ".attempt_ready"}, 32'(attempt_ready), 32'(m_mode == MODE_IDLE));
    checkOutput({tag, ".access_en"}, 32'(access_en), 32'(m_mode == MODE_SESSION));
    checkOutput({tag, ".locked"}, 32'(locked), 32'(m_mode == MODE_LOCKOUT));
    checkOutput({tag, ".fail_cnt"}, 32'(fail_cnt), 32'(m_fails));
    checkOutput({tag, ".expired"}, 32'(expired), 32'(m_expired));
  endtask

  // Drive one cycle of inputs, step the model on the edge, check just after it.
  task automatic applyStimulus(input logic v, input logic ok, input logic lo, input logic act,
                               input string tag);
    attempt_valid = v;
    attempt_ok = ok;
    logout = lo;
    activity = act;
    @(posedge clk);
    modelStep(v, ok, lo, act);
    #1;
    checkModel(tag);
  endtask

  // Pulse reset asynchronously and check outputs both during and after it.
  task automatic applyReset(input string tag);
    attempt_valid = 1'b0;
    attempt_ok = 1'b0;
    logout = 1'b0;
    activity = 1'b0;
    rst = 1'b1;
    #2;
    checkOutput({tag, ".rst_ready"}, 32'(attempt_ready), 32'd1);
    checkOutput({tag, ".rst_access"}, 32'(access_en), 32'd0);
    checkOutput({tag, ".rst_locked"}, 32'(locked), 32'd0);
    checkOutput({tag, ".rst_fail_cnt"}, 32'(fail_cnt), 32'd0);
    checkOutput({tag, ".rst_expired"}, 32'(expired), 32'd0);
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkModel(tag);
  endtask

  // Main sequence: table, directed corner cases, randomized run, summary.
  initial begin
    int n;
    int pulses;
    logic rv, rok, rlo, ract;

    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b0};

    applyReset("por");

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].v, vecs[i].ok, vecs[i].lo, vecs[i].act, $sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d.ready", i), 32'(attempt_ready), 32'(vecs[i].rdy));
      checkOutput($sformatf("vec%0d.access", i), 32'(access_en), 32'(vecs[i].acc));
      checkOutput($sformatf("vec%0d.locked", i), 32'(locked), 32'(vecs[i].lck));
      checkOutput($sformatf("vec%0d.fail_cnt", i), 32'(fail_cnt), 32'(vecs[i].fc));
      checkOutput($sformatf("vec%0d.expired", i), 32'(expired), 32'(vecs[i].ex));
    end

    // Three bad attempts, then measure the lockout length.
    applyReset("lock");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "lock.bad1");
    checkOutput("lock.fail1", 32'(fail_cnt), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "lock.bad2");
    checkOutput("lock.fail2", 32'(fail_cnt), 32'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "lock.bad3");
    checkOutput("lock.fail3", 32'(fail_cnt), 32'd3);
    n = 0;
    while (locked === 1'b1 && n < 2000) begin
      n++;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "lock.wait");
    end
    checkOutput("lock.length", 32'(n), 32'd128);
    checkOutput("lock.after_ready", 32'(attempt_ready), 32'd1);
    checkOutput("lock.after_fail_cnt", 32'(fail_cnt), 32'd0);

    // Good attempt with no further input: full session then one expiry pulse.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "sess.unlock");
    n = 0;
    while (access_en === 1'b1 && n < 2000) begin
      n++;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "sess.wait");
    end
    checkOutput("sess.length", 32'(n), 32'd256);
    checkOutput("sess.expired_pulse", 32'(expired), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "sess.post");
    checkOutput("sess.expired_clear", 32'(expired), 32'd0);

    // Two bad then one good: no lockout, counter clears.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "mix.bad1");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "mix.bad2");
    checkOutput("mix.fail2", 32'(fail_cnt), 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "mix.good");
    checkOutput("mix.fail0", 32'(fail_cnt), 32'd0);
    checkOutput("mix.access", 32'(access_en), 32'd1);
    checkOutput("mix.not_locked", 32'(locked), 32'd0);

    // Activity in the 200th session cycle renews the whole window.
    applyReset("act");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "act.unlock");
    n = 0;
    while (access_en === 1'b1 && n < 2000) begin
      n++;
      applyStimulus(1'b0, 1'b0, 1'b0, (n == 200), "act.wait");
    end
    checkOutput("act.length", 32'(n), 32'd456);

    // Logout together with activity at cycle 50 ends the session silently.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "lo.idle");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "lo.unlock");
    for (int i = 1; i < 50; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "lo.wait");
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, "lo.logout");
    checkOutput("lo.access_off", 32'(access_en), 32'd0);
    checkOutput("lo.ready", 32'(attempt_ready), 32'd1);
    pulses = (expired === 1'b1) ? 1 : 0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "lo.quiet");
      if (expired === 1'b1) pulses++;
    end
    checkOutput("lo.no_expired", 32'(pulses), 32'd0);

    // Reset in the middle of a lockout with ignored attempts along the way.
    applyReset("mid");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "mid.bad");
    end
    for (int i = 0; i < 59; i++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "mid.ignored");
    end
    checkOutput("mid.still_locked", 32'(locked), 32'd1);
    checkOutput("mid.fail_held", 32'(fail_cnt), 32'd3);
    applyReset("mid.rst");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "mid.first_bad");
    checkOutput("mid.fresh_fail", 32'(fail_cnt), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "mid.good");
    checkOutput("mid.fresh_access", 32'(access_en), 32'd1);

    // Randomized run with occasional resets, checked every cycle.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 2) begin
        applyReset("rand.rst");
      end else begin
        rv   = 1'($urandom_range(0, 99) < 30);
        rok  = 1'($urandom_range(0, 1));
        rlo  = 1'($urandom_range(0, 199) == 0);
        ract = 1'($urandom_range(0, 99) < 2);
        applyStimulus(rv, rok, rlo, ract, "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/pw_lockout_ctrl.md
PW_LOCKOUT_CTRL -- requirements
Module: pw_lockout_ctrl

Interface
REQ-001 SHALL have parameter PRESC_BITS, default 4: prescaler width; one timer tick every 2**PRESC_BITS clk cycles.
REQ-002 SHALL have parameter MAX_FAILS, default 3: consecutive failed attempts that trigger lockout; legal range >=1.
REQ-003 SHALL have parameter LOCK_TICKS, default 8: lockout duration in ticks; legal range >=1.
REQ-004 SHALL have parameter SESSION_TICKS, default 16: access window in ticks; legal range >=1.
REQ-005 SHALL have port clk, input, 1: clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port attempt_valid, input, 1: password comparison result present this cycle.
REQ-008 SHALL have port attempt_ok, input, 1: password matched; qualified by attempt_valid.
REQ-009 SHALL have port logout, input, 1: user ends session.
REQ-010 SHALL have port activity, input, 1: memory access occurred; restarts session window.
REQ-011 SHALL have port attempt_ready, output, 1: attempt accepted when attempt_valid and attempt_ready both high.
REQ-012 SHALL have port access_en, output, 1: memory access granted.
REQ-013 SHALL have port locked, output, 1: lockout in progress.
REQ-014 SHALL have port fail_cnt, output, $clog2(MAX_FAILS+1): consecutive failures.
REQ-015 SHALL have port expired, output, 1: one-cycle pulse on session timeout.

Function
REQ-016 SHALL implement states IDLE, UNLOCKED, LOCKED; outputs registered or decoded from state only.
REQ-017 attempt_ready SHALL be 1 only in IDLE; attempts presented outside IDLE are ignored and not counted.
REQ-018 Accepted attempt with attempt_ok=1 SHALL move to UNLOCKED next cycle; fail_cnt cleared to 0.
REQ-019 Accepted attempt with attempt_ok=0 SHALL increment fail_cnt; if new value equals MAX_FAILS, move to LOCKED next cycle, else stay IDLE.
REQ-020 fail_cnt SHALL hold MAX_FAILS throughout LOCKED and clear to 0 on LOCKED->IDLE; never exceeds MAX_FAILS.
REQ-021 On every entry to LOCKED or UNLOCKED, prescaler and tick counter SHALL be cleared in that same edge.
REQ-022 Tick SHALL assert for one cycle when prescaler equals 2**PRESC_BITS-1; prescaler wraps to 0.
REQ-023 LOCKED SHALL exit to IDLE on the tick where tick counter equals LOCK_TICKS-1; locked high exactly LOCK_TICKS*2**PRESC_BITS cycles.
REQ-024 UNLOCKED SHALL exit to IDLE on the tick where tick counter equals SESSION_TICKS-1, asserting expired for that one transition cycle.
REQ-025 logout in UNLOCKED SHALL move to IDLE next cycle without expired; logout wins over simultaneous timeout or activity.
REQ-026 activity in UNLOCKED (no logout) SHALL clear prescaler and tick counter, even on the timeout tick (timeout suppressed).
REQ-027 logout and activity SHALL be ignored in IDLE and LOCKED.
REQ-028 access_en SHALL equal (state==UNLOCKED); locked SHALL equal (state==LOCKED).

Reset
REQ-029 rst SHALL force state IDLE, fail_cnt 0, prescaler 0, tick counter 0, access_en 0, locked 0, expired 0, attempt_ready 1.
REQ-030 rst asserted mid-lockout or mid-session SHALL abort immediately; first post-reset accepted attempt behaves as from power-up.

Structure
REQ-031 State enum and fail_cnt/tick-counter width constants SHALL reside in shared package pw_ctrl_pkg.
REQ-032 Prescaler SHALL be sub-module pw_prescaler (PRESC_BITS wide, async rst, sync clear input, one-cycle tick output).

Verification (defaults: PRESC_BITS=4, MAX_FAILS=3, LOCK_TICKS=8, SESSION_TICKS=16)
REQ-033 Three bad attempts -> fail_cnt 1,2,3; locked high exactly 128 cycles; then IDLE, fail_cnt 0, attempt_ready 1.
REQ-034 Good attempt -> access_en high exactly 256 cycles, expired pulse 1 cycle, then IDLE.
REQ-035 Two bad then one good -> fail_cnt 2 then 0, access_en 1, no lockout.
REQ-036 Unlock, activity at cycle 200, no further input -> access_en stays high 456 cycles total from unlock.
REQ-037 Unlock, logout and activity same cycle at 50 -> IDLE next cycle, expired never pulses.
REQ-038 rst pulse at cycle 60 of LOCKED, attempts during LOCKED ignored -> all outputs reset values, fail_cnt 0.
